// File: rtl/psum_collector.sv
// Collects deskewed systolic-array psums, accumulates them over several
// passes per tile, then drains the accumulators as a valid/ready stream.
module psum_collector #(
   parameter int ARRAY_SIZE = 8,
   parameter int PSUM_W     = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [3:0]                   num_passes,
   input  logic                         psum_valid,
   input  logic [ARRAY_SIZE*PSUM_W-1:0] psums,
   output logic [PSUM_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         busy,
   output logic                         overflow,
   output logic                         protocol_err
);

   localparam int CW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam logic [CW-1:0] LAST = CW'(ARRAY_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CAPTURE,
      DRAIN
   } state_e;

   state_e            state_q, state_d;
   logic [PSUM_W-1:0] acc_q [ARRAY_SIZE];
   logic [PSUM_W-1:0] acc_d [ARRAY_SIZE];
   logic [CW-1:0]     col_cnt_q, col_cnt_d;
   logic [CW-1:0]     idx_q, idx_d;
   logic [3:0]        passes_q, passes_d;
   logic [3:0]        pass_cnt_q, pass_cnt_d;
   logic [3:0]        pass_cnt_inc;
   logic              ovf_q, ovf_d;
   logic              perr_q, perr_d;

   logic [PSUM_W-1:0] lane [ARRAY_SIZE];
   logic [CW-1:0]     sel;
   logic              cap;
   logic              pass_end;
   logic [PSUM_W-1:0] add_a, add_b, sum;
   logic              sum_ovf;

   for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
      assign lane[c] = psums[c*PSUM_W +: PSUM_W];
   end

   // One adder serves every lane: only one lane is captured per cycle.
   assign cap = (state_q == CAPTURE)
              | ((state_q == WAIT) & psum_valid);
   assign sel = (state_q == CAPTURE) ? col_cnt_q : '0;
   assign add_a = acc_q[sel];
   assign add_b = lane[sel];
   assign sum = add_a + add_b;
   assign sum_ovf = (add_a[PSUM_W-1] == add_b[PSUM_W-1])
                  & (sum[PSUM_W-1] != add_a[PSUM_W-1]);
   assign pass_end = cap & (sel == LAST);
   assign pass_cnt_inc = pass_cnt_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      col_cnt_d  = col_cnt_q;
      idx_d      = idx_q;
      passes_d   = passes_q;
      pass_cnt_d = pass_cnt_q;
      ovf_d      = ovf_q;
      perr_d     = perr_q | (psum_valid & (state_q != WAIT));
      unique case (state_q)
         IDLE: begin
            if (start) begin
               for (int i = 0; i < ARRAY_SIZE; i++) begin
                  acc_d[i] = '0;
               end
               passes_d   = (num_passes == 4'd0) ? 4'd1 : num_passes;
               pass_cnt_d = '0;
               col_cnt_d  = '0;
               idx_d      = '0;
               ovf_d      = 1'b0;
               perr_d     = psum_valid;
               state_d    = WAIT;
            end
         end
         WAIT, CAPTURE: begin
            if (cap) begin
               acc_d[sel] = sum;
               ovf_d      = ovf_q | sum_ovf;
               if (pass_end) begin
                  col_cnt_d  = '0;
                  pass_cnt_d = pass_cnt_inc;
                  state_d    = (pass_cnt_inc == passes_q) ? DRAIN : WAIT;
               end else begin
                  col_cnt_d = sel + 1'b1;
                  state_d   = CAPTURE;
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         col_cnt_q  <= '0;
         idx_q      <= '0;
         passes_q   <= 4'd1;
         pass_cnt_q <= '0;
         ovf_q      <= 1'b0;
         perr_q     <= 1'b0;
         for (int i = 0; i < ARRAY_SIZE; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         col_cnt_q  <= col_cnt_d;
         idx_q      <= idx_d;
         passes_q   <= passes_d;
         pass_cnt_q <= pass_cnt_d;
         ovf_q      <= ovf_d;
         perr_q     <= perr_d;
         for (int i = 0; i < ARRAY_SIZE; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

   assign out_valid    = (state_q == DRAIN);
   assign out_last     = out_valid & (idx_q == LAST);
   assign out_data     = out_valid ? acc_q[idx_q] : '0;
   assign busy         = (state_q != IDLE);
   assign overflow     = ovf_q;
   assign protocol_err = perr_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: deskewed capture, multi-pass
// accumulation, stalled drain, overflow, protocol errors and reset.
module tb_psum_collector;

   localparam int N = 8;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [3:0]     num_passes = 4'd0;
   logic           psum_valid = 1'b0;
   logic [N*W-1:0] psums = '0;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           out_last;
   logic           busy;
   logic           overflow;
   logic           protocol_err;

   int n_chk = 0;
   int n_pass = 0;

   logic [W-1:0] lanes [N];
   logic [W-1:0] expw [N];

   psum_collector #(
      .ARRAY_SIZE(N),
      .PSUM_W    (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_passes  (num_passes),
      .psum_valid  (psum_valid),
      .psums       (psums),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .overflow    (overflow),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Lane c carries its value; all other lanes carry junk.
   function automatic logic [N*W-1:0] mk(input int c);
      logic [N*W-1:0] v;
      for (int l = 0; l < N; l++) begin
         v[l*W +: W] = (l == c) ? lanes[l] : (32'h0BAD0000 | W'(l));
      end
      return v;
   endfunction

   task automatic start_tile(input logic [3:0] np);
      start = 1'b1;
      num_passes = np;
      @(negedge clk);
      start = 1'b0;
      check("busy_st", busy, 1);
      check("ovf_st", overflow, 0);
      check("perr_st", protocol_err, 0);
   endtask

   task automatic run_pass(input int glitch, input int st_at);
      for (int c = 0; c < N; c++) begin
         psum_valid = (c == 0) || (c == glitch);
         psums = mk(c);
         start = (c == st_at);
         if (c == st_at) num_passes = 4'd1;
         if (c == N - 1) check("ov_pre", out_valid, 0);
         @(negedge clk);
      end
      psum_valid = 1'b0;
      start = 1'b0;
      psums = '0;
   endtask

   task automatic drain(input bit stall, input bit start_last);
      int idx = 0;
      int k = 0;
      while (idx < N && k < 64) begin
         out_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
         start = start_last && out_ready && (idx == N - 1);
         check("dv", out_valid, 1);
         check("dd", out_data, expw[idx]);
         check("dl", out_last, idx == N - 1);
         if (out_ready) idx++;
         k++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      start = 1'b0;
      check("drain_n", idx, N);
      check("dv_end", out_valid, 0);
      check("busy_end", busy, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ov", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      check("rst_ovf", overflow, 0);
      check("rst_perr", protocol_err, 0);
      rst = 1'b1;
      @(negedge clk);

      // basic tile, start on final transfer is ignored
      start_tile(4'd1);
      for (int c = 0; c < N; c++) begin
         lanes[c] = W'(c + 1);
         expw[c] = W'(c + 1);
      end
      run_pass(-1, -1);
      drain(1'b0, 1'b1);

      // three passes, start while busy ignored
      start_tile(4'd3);
      for (int c = 0; c < N; c++) begin
         lanes[c] = 32'd10;
         expw[c] = 32'd30;
      end
      run_pass(-1, 2);
      check("ov_p1", out_valid, 0);
      run_pass(-1, -1);
      check("ov_p2", out_valid, 0);
      run_pass(-1, -1);
      drain(1'b0, 1'b0);
      check("perr_clean", protocol_err, 0);

      // stalled drain
      start_tile(4'd1);
      for (int c = 0; c < N; c++) begin
         lanes[c] = W'(100 + 7 * c);
         expw[c] = W'(100 + 7 * c);
      end
      run_pass(-1, -1);
      drain(1'b1, 1'b0);

      // signed overflow
      start_tile(4'd2);
      for (int c = 0; c < N; c++) begin
         lanes[c] = '0;
         expw[c] = '0;
      end
      lanes[0] = 32'h7FFFFFFF;
      run_pass(-1, -1);
      check("ovf_p1", overflow, 0);
      lanes[0] = 32'd1;
      run_pass(-1, -1);
      check("ovf_p2", overflow, 1);
      expw[0] = 32'h80000000;
      drain(1'b0, 1'b0);
      check("ovf_hold", overflow, 1);
      start_tile(4'd0);
      lanes[0] = '0;
      expw[0] = '0;
      run_pass(-1, -1);
      drain(1'b0, 1'b0);

      // protocol errors in IDLE and CAPTURE
      psum_valid = 1'b1;
      @(negedge clk);
      psum_valid = 1'b0;
      check("perr_idle", protocol_err, 1);
      check("busy_idle", busy, 0);
      start_tile(4'd1);
      for (int c = 0; c < N; c++) begin
         lanes[c] = W'(2 * c + 3);
         expw[c] = W'(2 * c + 3);
      end
      run_pass(3, -1);
      check("perr_cap", protocol_err, 1);
      drain(1'b0, 1'b0);

      // reset on the 4th CAPTURE cycle
      start_tile(4'd1);
      for (int c = 0; c < N; c++) lanes[c] = 32'd9;
      for (int c = 0; c < 4; c++) begin
         psum_valid = (c == 0) || (c == 2);
         psums = mk(c);
         @(negedge clk);
      end
      check("perr_pre", protocol_err, 1);
      rst = 1'b0;
      psum_valid = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_ov", out_valid, 0);
      check("mr_data", out_data, 0);
      check("mr_last", out_last, 0);
      check("mr_ovf", overflow, 0);
      check("mr_perr", protocol_err, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start_tile(4'd1);
      for (int c = 0; c < N; c++) begin
         lanes[c] = 32'd5;
         expw[c] = 32'd5;
      end
      run_pass(-1, -1);
      drain(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
